// File: rtl/capture_dump_if.sv
// capture_dump_if: channel inputs, capture request and UART/status outputs of capture_dump
interface capture_dump_if #(parameter int NCH = 2);
  logic [NCH-1:0] sig;
  logic hold;
  logic start;
  logic fpga_tx;
  logic busy;
  logic done;
  modport slave(input sig, hold, start, output fpga_tx, busy, done);
  modport master(output sig, hold, start, input fpga_tx, busy, done);
endinterface

// File: rtl/capture_dump.sv
// capture_dump: captures DEPTH samples of NCH channels, then dumps them as ASCII hex lines over UART 8N1
module capture_dump #(
  parameter int NCH = 2,
  parameter int DEPTH = 256,
  parameter int DECIM = 1,
  parameter int CLKS_PER_BIT = 40
) (
  input logic clk,
  input logic rst,
  capture_dump_if.slave io
);
  localparam int H = (NCH + 3) / 4;
  localparam int XW = 4 * H;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(H + 1);
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  typedef enum logic [1:0] {IDLE, CAPTURE, DUMP} state_t;
  state_t state, state_nx;
  logic [NCH-1:0] mem [DEPTH];
  logic [AW-1:0] addr;
  logic [CW-1:0] ccnt;
  logic [3:0] bcnt;
  logic [NW-1:0] ncnt, dig;
  logic [DW-1:0] dcnt;
  logic [XW-1:0] ext;
  logic [3:0] nib;
  logic [7:0] chr;
  logic [9:0] frame;
  logic wr, bit_end, byte_end, line_end, last, done_q;
  always_comb begin
    wr = state == CAPTURE && dcnt == '0;
    bit_end = state == DUMP && ccnt == CW'(CLKS_PER_BIT - 1);
    byte_end = bit_end && bcnt == 4'd9;
    line_end = byte_end && ncnt == NW'(H);
    last = line_end && addr == AW'(DEPTH - 1);
    ext = XW'(mem[addr]);
    dig = NW'(H - 1) - ncnt;
    nib = 4'(ext >> {dig, 2'b00});
    chr = ncnt == NW'(H) ? 8'h0A : nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    frame = {1'b1, chr, 1'b0};
    state_nx = state == IDLE ? (io.start ? CAPTURE : IDLE)
             : state == CAPTURE ? (wr && addr == AW'(DEPTH - 1) ? DUMP : CAPTURE)
             : (last ? IDLE : DUMP);
  end
  assign io.fpga_tx = state == DUMP ? frame[bcnt] : 1'b1;
  assign io.busy = state != IDLE;
  assign io.done = done_q;
  // addr wraps to zero naturally after DEPTH-1, handing over cleanly between capture and dump
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      ccnt <= '0;
      bcnt <= '0;
      ncnt <= '0;
      dcnt <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_nx;
      done_q <= last;
      if (state == CAPTURE) dcnt <= (dcnt == DW'(DECIM - 1) || state_nx != CAPTURE) ? '0 : dcnt + 1'b1;
      if (wr || line_end) addr <= addr + 1'b1;
      if (state == DUMP) ccnt <= bit_end ? '0 : ccnt + 1'b1;
      if (bit_end) bcnt <= byte_end ? '0 : bcnt + 1'b1;
      if (byte_end) ncnt <= line_end ? '0 : ncnt + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem[addr] <= io.hold ? '1 : io.sig;
endmodule

// File: tb/tb_capture_dump.sv
// tb_capture_dump: randomized capture/dump scenarios checked against a sample-level model and a cycle-exact UART decoder
module tb_capture_dump;
  localparam int DEPTH = 16, CPB = 4, FB = 10 * CPB;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, failures = 0, done_cnt0 = 0;
  int vals[$], samp_q[$];
  bit hv[$], sv[$];
  logic [7:0] got_q[$], exp_q[$];
  logic bits_q[$];
  int lat;
  bit tmo, ferr, busy_bad, done_early, done_after, busy_after, done2;
  capture_dump_if #(.NCH(2)) i0 ();
  capture_dump_if #(.NCH(5)) i1 ();
  capture_dump_if #(.NCH(2)) i2 ();
  capture_dump #(.NCH(2), .DEPTH(DEPTH), .DECIM(1), .CLKS_PER_BIT(CPB)) u0 (.clk(clk), .rst(rst), .io(i0));
  capture_dump #(.NCH(5), .DEPTH(DEPTH), .DECIM(1), .CLKS_PER_BIT(CPB)) u1 (.clk(clk), .rst(rst), .io(i1));
  capture_dump #(.NCH(2), .DEPTH(DEPTH), .DECIM(3), .CLKS_PER_BIT(CPB)) u2 (.clk(clk), .rst(rst), .io(i2));
  always @(negedge clk) if (i0.done === 1'b1) done_cnt0++;
  function automatic logic tx_of(input int w);
    return w == 0 ? i0.fpga_tx : w == 1 ? i1.fpga_tx : i2.fpga_tx;
  endfunction
  function automatic logic busy_of(input int w);
    return w == 0 ? i0.busy : w == 1 ? i1.busy : i2.busy;
  endfunction
  function automatic logic done_of(input int w);
    return w == 0 ? i0.done : w == 1 ? i1.done : i2.done;
  endfunction
  task automatic set_in(input int w, input int s, input bit h, input bit st);
    if (w == 0) begin i0.sig = 2'(s); i0.hold = h; i0.start = st; end
    else if (w == 1) begin i1.sig = 5'(s); i1.hold = h; i1.start = st; end
    else begin i2.sig = 2'(s); i2.hold = h; i2.start = st; end
  endtask
  function automatic int diff_count();
    int n = got_q.size() > exp_q.size() ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction
  task automatic stim(input int len, input int maxv, input bit rnd_hold);
    vals.delete(); hv.delete(); sv.delete();
    for (int c = 0; c < len; c++) begin
      vals.push_back($urandom_range(0, maxv));
      hv.push_back(rnd_hold && $urandom_range(0, 3) == 0);
      sv.push_back(1'b0);
    end
  endtask
  // reference: stored sample k is whatever was presented k*decim cycles after the accept edge, hex-printed per line
  task automatic build_exp(input int nch, input int decim);
    int h = (nch + 3) / 4;
    int mask = (1 << nch) - 1;
    samp_q.delete(); exp_q.delete();
    for (int k = 0; k < DEPTH; k++) samp_q.push_back(hv[k * decim] ? mask : vals[k * decim] & mask);
    foreach (samp_q[k]) begin
      for (int d = h - 1; d >= 0; d--) begin
        int n = (samp_q[k] >> (4 * d)) & 15;
        exp_q.push_back(8'(n < 10 ? 48 + n : 55 + n));
      end
      exp_q.push_back(8'h0A);
    end
  endtask
  task automatic drive(input int w);
    for (int c = 0; c < vals.size(); c++) begin
      set_in(w, vals[c], hv[c], sv[c]);
      @(posedge clk); #1;
    end
    set_in(w, 0, 1'b0, 1'b0);
  endtask
  task automatic collect(input int w, input int nbytes);
    bits_q.delete(); got_q.delete();
    tmo = 0; ferr = 0; busy_bad = 0; done_early = 0; done_after = 0; busy_after = 1; done2 = 1; lat = 0;
    while (!tmo) begin
      @(negedge clk); lat++;
      if (busy_of(w) !== 1'b1) busy_bad = 1;
      if (tx_of(w) === 1'b0) break;
      if (lat > 4000) tmo = 1;
    end
    if (tmo) return;
    bits_q.push_back(1'b0);
    for (int i = 1; i < nbytes * FB; i++) begin
      @(negedge clk);
      bits_q.push_back(tx_of(w));
      if (done_of(w) !== 1'b0 || busy_of(w) !== 1'b1) done_early = 1;
    end
    @(negedge clk); done_after = done_of(w); busy_after = busy_of(w);
    @(negedge clk); done2 = done_of(w);
    for (int b = 0; b < nbytes; b++) begin
      logic [9:0] f;
      for (int k = 0; k < 10; k++) begin
        f[k] = bits_q[b * FB + k * CPB];
        for (int j = 1; j < CPB; j++) if (bits_q[b * FB + k * CPB + j] !== f[k]) ferr = 1;
      end
      if (f[0] !== 1'b0 || f[9] !== 1'b1) ferr = 1;
      got_q.push_back(f[8:1]);
    end
  endtask
  task automatic run(input int w, input int nch, input int decim, input int nbytes);
    build_exp(nch, decim);
    @(posedge clk); #1; set_in(w, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    fork
      drive(w);
      collect(w, nbytes);
    join
  endtask
  task automatic test_reset;
    for (int w = 0; w < 3; w++) set_in(w, 0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      checks++;
      if ({tx_of(w), busy_of(w), done_of(w)} !== 3'b100) begin
        failures++; $display("FAIL reset_outputs dut=%0d tx/busy/done=%b want=100", w, {tx_of(w), busy_of(w), done_of(w)});
      end
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({i0.fpga_tx, i0.busy} !== 2'b10) begin
      failures++; $display("FAIL idle_after_release tx/busy=%b want=10", {i0.fpga_tx, i0.busy});
    end
  endtask
  task automatic test_const;
    logic [9:0] exp_f = 10'b1001100100;
    int bad = 0;
    stim(18, 0, 1'b0);
    foreach (vals[c]) vals[c] = 2;
    run(0, 2, 1, 32);
    checks++;
    if (tmo || lat !== 17) begin failures++; $display("FAIL const_first_start_bit lat=%0d want=17", lat); end
    checks++;
    if (diff_count() != 0 || exp_q[0] !== 8'h32) begin failures++; $display("FAIL const_bytes diffs=%0d got_n=%0d want_n=%0d", diff_count(), got_q.size(), exp_q.size()); end
    for (int i = 0; i < FB; i++) if (i >= bits_q.size() || bits_q[i] !== exp_f[i / CPB]) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL const_first_frame bad_cycles=%0d want=0", bad); end
    checks++;
    if (ferr || busy_bad) begin failures++; $display("FAIL const_framing ferr=%0b busy_bad=%0b want=0,0", ferr, busy_bad); end
    checks++;
    if ({done_early, done_after, busy_after, done2} !== 4'b0100) begin
      failures++; $display("FAIL const_done_at_1280 early/done/busy/next=%b want=0100", {done_early, done_after, busy_after, done2});
    end
  endtask
  task automatic test_hold;
    stim(18, 0, 1'b0);
    for (int c = 4; c < 8; c++) hv[c] = 1'b1;
    run(0, 2, 1, 32);
    checks++;
    if (tmo || diff_count() != 0 || got_q[8] !== 8'h33 || got_q[6] !== 8'h30) begin
      failures++; $display("FAIL hold_blanking diffs=%0d line3=%h line4=%h want=30,33", diff_count(), got_q[6], got_q[8]);
    end
  endtask
  task automatic test_random;
    for (int r = 0; r < 2; r++) begin
      stim(18, 3, 1'b1);
      run(0, 2, 1, 32);
      checks++;
      if (tmo || diff_count() != 0 || ferr) begin failures++; $display("FAIL random_nch2 round=%0d diffs=%0d ferr=%0b want=0,0", r, diff_count(), ferr); end
    end
  endtask
  task automatic test_wide;
    stim(18, 0, 1'b0);
    foreach (vals[c]) vals[c] = 'h1A;
    run(1, 5, 1, 48);
    checks++;
    if (tmo || diff_count() != 0 || got_q.size() != 48 || got_q[1] !== 8'h41) begin
      failures++; $display("FAIL wide_1A diffs=%0d bytes=%0d want=0,48", diff_count(), got_q.size());
    end
    stim(18, 31, 1'b1);
    run(1, 5, 1, 48);
    checks++;
    if (tmo || diff_count() != 0 || ferr || {done_after, busy_after, done2} !== 3'b100) begin
      failures++; $display("FAIL wide_random diffs=%0d ferr=%0b done/busy/next=%b want=0,0,100", diff_count(), ferr, {done_after, busy_after, done2});
    end
  endtask
  task automatic test_decim;
    stim(50, 0, 1'b0);
    foreach (vals[c]) vals[c] = c % 4;
    run(2, 2, 3, 32);
    checks++;
    if (tmo || lat !== 47) begin failures++; $display("FAIL decim_latency lat=%0d want=47", lat); end
    checks++;
    if (diff_count() != 0 || got_q[2] !== 8'h33 || got_q[4] !== 8'h32) begin
      failures++; $display("FAIL decim_sequence diffs=%0d s1=%h s2=%h want=33,32", diff_count(), got_q[2], got_q[4]);
    end
    stim(50, 3, 1'b1);
    run(2, 2, 3, 32);
    checks++;
    if (tmo || diff_count() != 0 || ferr) begin failures++; $display("FAIL decim_random diffs=%0d ferr=%0b want=0,0", diff_count(), ferr); end
  endtask
  task automatic test_ignore_start;
    int d0;
    stim(1400, 3, 1'b1);
    sv[3] = 1'b1; sv[9] = 1'b1; sv[200] = 1'b1; sv[900] = 1'b1;
    d0 = done_cnt0;
    run(0, 2, 1, 32);
    checks++;
    if (tmo || diff_count() != 0 || done_early) begin failures++; $display("FAIL ignore_start_dump diffs=%0d early_done=%0b want=0,0", diff_count(), done_early); end
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt0 - d0 != 1 || i0.busy !== 1'b0) begin
      failures++; $display("FAIL ignore_start_single done_pulses=%0d busy=%b want=1,0", done_cnt0 - d0, i0.busy);
    end
  endtask
  task automatic test_reset_mid;
    int d0 = done_cnt0;
    @(posedge clk); #1; set_in(0, 2, 1'b0, 1'b1);
    @(posedge clk); #1; set_in(0, 2, 1'b0, 1'b0);
    repeat (17 + 5 * FB) @(negedge clk);
    checks++;
    if (i0.fpga_tx !== 1'b0) begin failures++; $display("FAIL reset_mid_prestate tx=%b want=0", i0.fpga_tx); end
    #2; rst = 1'b0; #1;
    checks++;
    if ({i0.fpga_tx, i0.busy, i0.done} !== 3'b100) begin
      failures++; $display("FAIL reset_mid_async tx/busy/done=%b want=100", {i0.fpga_tx, i0.busy, i0.done});
    end
    set_in(0, 2, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (i0.busy !== 1'b1) begin failures++; $display("FAIL start_through_release busy=%b want=1", i0.busy); end
    set_in(0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (done_cnt0 != d0 || i0.busy !== 1'b0 || i0.fpga_tx !== 1'b1) begin
      failures++; $display("FAIL reset_mid_no_done done_pulses=%0d busy=%b tx=%b want=0,0,1", done_cnt0 - d0, i0.busy, i0.fpga_tx);
    end
  endtask
  initial begin
    test_reset();
    test_const();
    test_hold();
    test_random();
    test_wide();
    test_decim();
    test_ignore_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
